core_run_monitor: RTL and testbench
===================================

Name: core_run_monitor

Overview:
- Synthesizable run controller placed between the board clock/reset and a core under test.
- Holds the core in reset for a configurable number of cycles, then releases it and counts run cycles.
- Detects a core halt report or a timeout and latches pass/fail status and the result code.
- Supports re-running the core on command without a board reset.

Parameters:
- RST_HOLD_CYCLES, 10: cycles core_resetn stays low before each run; legal range is 1 or more.
- CNT_W, 32: width of the cycle counter.
- TIMEOUT_CYCLES, 100000: run-cycle limit; 0 disables the timeout; must be below 2^CNT_W.
- RESULT_W, 32: width of the halt code.
- PASS_CODE, 1: halt code that counts as a pass.

Ports:
- CLK100MHZ  in  1  system clock; all logic is on the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- start  in  1  rerun request; sampled only in the DONE state.
- halt_valid  in  1  core reports a halt; sampled only in the RUN state.
- halt_code  in  RESULT_W  core result; valid together with halt_valid.
- core_resetn  out  1  registered active-low reset to the core.
- running  out  1  high while in the RUN state.
- done  out  1  high while in the DONE state.
- pass  out  1  the run ended by halt with halt_code == PASS_CODE.
- timeout  out  1  the run ended by timeout.
- cycle_count  out  CNT_W  run cycles elapsed.
- result  out  RESULT_W  latched halt_code.

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - State goes to HOLD and the hold counter clears to 0.
  - core_resetn = 0, running = 0, done = 0, pass = 0, timeout = 0, cycle_count = 0, result = 0.
  - Asserting reset mid-run aborts immediately with the same values.
- States: HOLD, RUN, DONE. All outputs are registered.
- HOLD:
  - core_resetn = 0.
  - The hold counter increments each edge.
  - On the edge where the hold counter == RST_HOLD_CYCLES-1: go to RUN, core_resetn <= 1, running <= 1, cycle_count <= 0.
  - core_resetn therefore rises on the RST_HOLD_CYCLES-th rising edge after CPU_RESETN deasserts or after a start is accepted.
  - halt_valid and start are ignored.
- RUN, priority within one edge:
  1. halt_valid = 1: result <= halt_code, pass <= (halt_code == PASS_CODE), done <= 1, running <= 0, core_resetn <= 0. cycle_count is not incremented and keeps the number of RUN edges that preceded the halt edge; a halt on the first RUN edge gives cycle_count = 0. Go to DONE.
  2. Else, if TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES-1: cycle_count <= TIMEOUT_CYCLES, timeout <= 1, pass <= 0, done <= 1, running <= 0, core_resetn <= 0. Go to DONE.
  3. Else: cycle_count <= cycle_count + 1, saturating at 2^CNT_W-1 with no wrap.
  - A halt on the same edge as the timeout is reported as a halt; timeout stays 0.
  - start is ignored.
- DONE:
  - core_resetn = 0; all status outputs hold their values.
  - halt_valid is ignored.
  - start = 1: clear pass, timeout, done and result; keep cycle_count until the next RUN entry. Hold counter <= 0. Go to HOLD.
- Exactly one of pass/timeout/fail is meaningful while done = 1.
  - Fail means done = 1, pass = 0, timeout = 0.
- Widths: comparisons are unsigned and at full width. PASS_CODE is truncated or zero-extended to RESULT_W.

Test Plan:
- Reset release, RST_HOLD_CYCLES=10 -> core_resetn goes high exactly at the 10th rising edge after CPU_RESETN goes high; running=1, cycle_count=0.
- halt_valid pulse with halt_code=1 after 25 RUN edges -> done=1, pass=1, timeout=0, result=1, cycle_count=25, core_resetn=0 on the next edge.
- halt_code=0xDEAD -> done=1, pass=0, timeout=0, result=0xDEAD.
- TIMEOUT_CYCLES=50, no halt -> timeout=1, done=1, cycle_count=50; a second variant asserts halt_valid on that same edge -> pass path, timeout=0.
- In DONE, pulse start -> flags clear, core_resetn low for 10 edges, then a new run starts at cycle_count=0; start pulses during HOLD/RUN have no effect.
- CPU_RESETN pulled low mid-RUN (asynchronously, between edges) -> all outputs are at reset values before the next edge; after release the full HOLD sequence repeats.

Source files
------------

// File: rtl/core_run_monitor.sv
// Run controller for a core under test: holds the core in reset, lets it run,
// then latches how the run ended (halt with pass/fail code, or timeout).
module core_run_monitor #(
  parameter int unsigned     RST_HOLD_CYCLES = 10,
  parameter int unsigned     CNT_W           = 32,
  parameter longint unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned     RESULT_W        = 32,
  parameter longint unsigned PASS_CODE       = 1
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                start,
  input  logic                halt_valid,
  input  logic [RESULT_W-1:0] halt_code,
  output logic                core_resetn,
  output logic                running,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [RESULT_W-1:0] result
);

  localparam int unsigned         HOLD_W       = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST    = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam bit                  TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]    TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = TIMEOUT_VAL - CNT_W'(1);
  localparam logic [RESULT_W-1:0] PASS_VAL     = RESULT_W'(PASS_CODE);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                core_resetn_q, core_resetn_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RESULT_W-1:0] result_q, result_d;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value so no path leaves one unassigned (no latches).
    state_d       = state_q;
    hold_d        = hold_q;
    core_resetn_d = core_resetn_q;
    running_d     = running_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    count_d       = count_q;
    result_d      = result_q;

    case (state_q)
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          state_d       = ST_RUN;
          hold_d        = '0;
          core_resetn_d = 1'b1;
          running_d     = 1'b1;
          count_d       = '0;
        end
      end

      ST_RUN: begin
        // A halt wins over a timeout landing on the same edge.
        if (halt_valid) begin
          state_d       = ST_DONE;
          result_d      = halt_code;
          pass_d        = (halt_code == PASS_VAL);
          done_d        = 1'b1;
          running_d     = 1'b0;
          core_resetn_d = 1'b0;
        end else if (TIMEOUT_EN && (count_q == TIMEOUT_LAST)) begin
          state_d       = ST_DONE;
          count_d       = TIMEOUT_VAL;
          timeout_d     = 1'b1;
          pass_d        = 1'b0;
          done_d        = 1'b1;
          running_d     = 1'b0;
          core_resetn_d = 1'b0;
        end else if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // cycle_count stays visible until the next run actually starts.
        if (start) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          result_d  = '0;
        end
      end

      default: begin
        state_d       = ST_HOLD;
        hold_d        = '0;
        core_resetn_d = 1'b0;
        running_d     = 1'b0;
        done_d        = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q       <= ST_HOLD;
      hold_q        <= '0;
      core_resetn_q <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      count_q       <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      core_resetn_q <= core_resetn_d;
      running_q     <= running_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      count_q       <= count_d;
      result_q      <= result_d;
    end
  end

  assign core_resetn = core_resetn_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign cycle_count = count_q;
  assign result      = result_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: directed run scenarios with literal expectations,
// then randomized stimulus checked every cycle against a phase-level model.
module tb_core_run_monitor;

  localparam int A_HOLD   = 10;
  localparam int A_CNT_W  = 8;
  localparam int A_TO     = 50;
  localparam int A_RES_W  = 16;
  localparam int A_PASS   = 1;
  localparam int A_CNTMAX = (1 << A_CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                 start      = 1'b0;
  logic                 halt_valid = 1'b0;
  logic [A_RES_W-1:0]   halt_code  = '0;
  logic                 a_core_resetn, a_running, a_done, a_pass, a_timeout;
  logic [A_CNT_W-1:0]   a_count;
  logic [A_RES_W-1:0]   a_result;

  logic       b_start      = 1'b0;
  logic       b_halt_valid = 1'b0;
  logic [7:0] b_halt_code  = '0;
  logic       b_core_resetn, b_running, b_done, b_pass, b_timeout;
  logic [3:0] b_count;
  logic [7:0] b_result;

  core_run_monitor #(
    .RST_HOLD_CYCLES(A_HOLD), .CNT_W(A_CNT_W), .TIMEOUT_CYCLES(A_TO),
    .RESULT_W(A_RES_W), .PASS_CODE(A_PASS)
  ) u_dut_a (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start), .halt_valid(halt_valid),
    .halt_code(halt_code), .core_resetn(a_core_resetn), .running(a_running),
    .done(a_done), .pass(a_pass), .timeout(a_timeout), .cycle_count(a_count),
    .result(a_result)
  );

  // Second instance: one-cycle hold, no timeout, narrow counter, truncated pass code.
  core_run_monitor #(
    .RST_HOLD_CYCLES(1), .CNT_W(4), .TIMEOUT_CYCLES(0), .RESULT_W(8), .PASS_CODE(64'h1FF)
  ) u_dut_b (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(b_start), .halt_valid(b_halt_valid),
    .halt_code(b_halt_code), .core_resetn(b_core_resetn), .running(b_running),
    .done(b_done), .pass(b_pass), .timeout(b_timeout), .cycle_count(b_count),
    .result(b_result)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the run is in, plus the latched status.
  typedef enum {M_HOLD, M_RUN, M_DONE} phase_t;
  phase_t             m_phase;
  int                 m_hold_edges;
  int                 m_count;
  logic [A_RES_W-1:0] m_result;
  bit                 m_pass, m_to;

  task automatic model_reset();
    m_phase      = M_HOLD;
    m_hold_edges = 0;
    m_count      = 0;
    m_result     = '0;
    m_pass       = 1'b0;
    m_to         = 1'b0;
  endtask

  task automatic model_edge();
    case (m_phase)
      M_HOLD: begin
        m_hold_edges++;
        if (m_hold_edges == A_HOLD) begin
          m_phase = M_RUN;
          m_count = 0;
        end
      end
      M_RUN: begin
        if (halt_valid) begin
          m_result = halt_code;
          m_pass   = (halt_code == A_PASS);
          m_phase  = M_DONE;
        end else if (A_TO != 0 && m_count + 1 == A_TO) begin
          m_count = A_TO;
          m_to    = 1'b1;
          m_pass  = 1'b0;
          m_phase = M_DONE;
        end else begin
          m_count = (m_count + 1 > A_CNTMAX) ? A_CNTMAX : m_count + 1;
        end
      end
      default: begin
        if (start) begin
          m_pass       = 1'b0;
          m_to         = 1'b0;
          m_result     = '0;
          m_hold_edges = 0;
          m_phase      = M_HOLD;
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("core_resetn", a_core_resetn, m_phase == M_RUN);
      check("running", a_running, m_phase == M_RUN);
      check("done", a_done, m_phase == M_DONE);
      check("pass", a_pass, m_pass);
      check("timeout", a_timeout, m_to);
      check("cycle_count", a_count, m_count);
      check("result", a_result, m_result);
    end
  end

  task automatic step(input logic s, input logic hv, input logic [A_RES_W-1:0] hc);
    @(negedge clk);
    start      = s;
    halt_valid = hv;
    halt_code  = hc;
    @(posedge clk);
    #1;
  endtask

  task automatic restart_a();
    step(1'b1, 1'b0, '0);
    repeat (A_HOLD) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_core_resetn", a_core_resetn, 1'b0);
    check("rst_running", a_running, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_count", a_count, 0);
    check("rst_result", a_result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk); #1;
    check("b_release", b_core_resetn, 1'b1);
    check("b_count0", b_count, 0);
    repeat (A_HOLD - 2) @(posedge clk);
    #1;
    check("hold_edge9", a_core_resetn, 1'b0);
    @(posedge clk); #1;
    check("hold_edge10", a_core_resetn, 1'b1);
    check("run_entry_running", a_running, 1'b1);
    check("run_entry_count", a_count, 0);

    for (int i = 0; i < 25; i++) step(i % 7 == 3, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0001);
    check("halt1_done", a_done, 1'b1);
    check("halt1_pass", a_pass, 1'b1);
    check("halt1_timeout", a_timeout, 1'b0);
    check("halt1_result", a_result, 16'h0001);
    check("halt1_count", a_count, 25);
    check("halt1_core_resetn", a_core_resetn, 1'b0);
    check("b_saturated", b_count, 4'hF);
    check("b_no_timeout", b_timeout, 1'b0);
    check("b_still_running", b_running, 1'b1);

    b_halt_valid = 1'b1;
    b_halt_code  = 8'hFF;
    step(1'b0, 1'b1, 16'h0005);
    b_halt_valid = 1'b0;
    check("done_ignores_halt", a_result, 16'h0001);
    check("b_pass_trunc", b_pass, 1'b1);
    check("b_result", b_result, 8'hFF);
    check("b_count_held", b_count, 4'hF);

    step(1'b1, 1'b0, '0);
    check("start_clears_done", a_done, 1'b0);
    check("start_clears_pass", a_pass, 1'b0);
    check("start_clears_result", a_result, 0);
    check("start_keeps_count", a_count, 25);
    for (int i = 0; i < A_HOLD - 1; i++) step(i % 2 == 1, i == 4, 16'h0001);
    check("rerun_hold9", a_core_resetn, 1'b0);
    check("rerun_hold_count", a_count, 25);
    step(1'b0, 1'b0, '0);
    check("rerun_release", a_core_resetn, 1'b1);
    check("rerun_count0", a_count, 0);

    repeat (7) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'hDEAD);
    check("dead_done", a_done, 1'b1);
    check("dead_pass", a_pass, 1'b0);
    check("dead_timeout", a_timeout, 1'b0);
    check("dead_result", a_result, 16'hDEAD);
    check("dead_count", a_count, 7);

    restart_a();
    repeat (A_TO - 1) step(1'b0, 1'b0, '0);
    check("pre_timeout_count", a_count, A_TO - 1);
    step(1'b0, 1'b0, '0);
    check("to_timeout", a_timeout, 1'b1);
    check("to_done", a_done, 1'b1);
    check("to_pass", a_pass, 1'b0);
    check("to_count", a_count, A_TO);

    restart_a();
    repeat (A_TO - 1) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0001);
    check("tie_pass", a_pass, 1'b1);
    check("tie_timeout", a_timeout, 1'b0);
    check("tie_count", a_count, A_TO - 1);

    restart_a();
    repeat (5) step(1'b0, 1'b0, '0);
    #3 rst_n = 1'b0;
    #1;
    check("abort_core_resetn", a_core_resetn, 1'b0);
    check("abort_running", a_running, 1'b0);
    check("abort_count", a_count, 0);
    check("abort_b_done", b_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (A_HOLD - 1) @(posedge clk);
    #1;
    check("abort_hold9", a_core_resetn, 1'b0);
    @(posedge clk); #1;
    check("abort_hold10", a_core_resetn, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step($urandom_range(3) == 0, $urandom_range(29) == 0,
             ($urandom_range(1) == 0) ? 16'h0001 : 16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
